// File: rtl/fifo_unpacker_pkg.sv
// ============================================================================
// Module      : fifo_unpacker_pkg
// Description : Shared widths and derivations for the width-converting FIFOs
//               (transmit-side unpacker and receive-side packer).
//               Holds default geometry plus helpers that derive the slice
//               ratio, lane-counter width, pointer width and count width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_unpacker_pkg;

    localparam int DEF_IN_WIDTH   = 4;
    localparam int DEF_OUT_WIDTH  = 2;
    localparam int DEF_WORD_DEPTH = 8;

    // Number of narrow slices that make up one wide word.
    function automatic int calc_ratio(input int wide_w, input int narrow_w);
        return wide_w / narrow_w;
    endfunction

    // Lane counter needs at least one bit even when the ratio is 1.
    function automatic int calc_lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Pointers wrap naturally because the depth is a power of two.
    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a full FIFO (count == depth) is representable.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_unpacker.sv
// ============================================================================
// Module      : fifo_unpacker
// Description : Word-wide FIFO read out as narrower slices, MSB slice first.
//               Each accepted read returns one slice one cycle later; the
//               word is popped when its last slice is read.
// Ports       : clk        - sole clock, rising edge
//               rst        - synchronous active-high reset
//               w_en       - write request (dropped while full)
//               data_in    - IN_WIDTH word to store
//               r_en       - request for one slice (ignored while empty)
//               data_out   - registered OUT_WIDTH slice, holds between reads
//               data_valid - data_out is a newly read slice this cycle
//               data_last  - data_out is the final slice of its word
//               full       - word count equals WORD_DEPTH
//               empty      - word count equals 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_unpacker
    import fifo_unpacker_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int WORD_DEPTH = DEF_WORD_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 r_en,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 data_last,
    output logic                 full,
    output logic                 empty
);

    localparam int c_ratio  = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int c_lane_w = calc_lane_w(c_ratio);
    localparam int c_ptr_w  = calc_ptr_w(WORD_DEPTH);
    localparam int c_cnt_w  = calc_cnt_w(WORD_DEPTH);

    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_ratio - 1);
    localparam logic [c_cnt_w-1:0]  c_full_cnt  = c_cnt_w'(WORD_DEPTH);

    logic [IN_WIDTH-1:0]  r_mem [WORD_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_lane_w-1:0]  r_lane;
    logic [OUT_WIDTH-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_data_last;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_lane_last;
    logic                 w_pop;
    logic [IN_WIDTH-1:0]  w_head;
    logic [IN_WIDTH-1:0]  w_head_shifted;
    logic [OUT_WIDTH-1:0] w_slice;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);

    // Full is judged on the current count, so a write is dropped even if a
    // pop frees a slot on the same edge.
    assign w_wr_acc    = w_en & ~w_full;
    assign w_rd_acc    = r_en & ~w_empty;
    assign w_lane_last = (r_lane == c_last_lane);
    assign w_pop       = w_rd_acc & w_lane_last;

    // Lane 0 is the MSB slice: shift the head word right by the number of
    // slices that sit below the selected one.
    always_comb begin
        int v_shift;
        v_shift        = (c_ratio - 1 - int'(r_lane)) * OUT_WIDTH;
        w_head         = r_mem[r_rd_ptr];
        w_head_shifted = w_head >> v_shift;
        w_slice        = w_head_shifted[OUT_WIDTH-1:0];
    end

    // Storage is not reset; only the pointers and count give it meaning.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_lane       <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            r_data_last  <= w_pop;

            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end

            if (w_rd_acc) begin
                r_data_out <= w_slice;
                if (w_lane_last) begin
                    r_lane   <= '0;
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end else begin
                    r_lane   <= r_lane + c_lane_w'(1);
                end
            end

            if (w_wr_acc && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_wr_acc && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign data_last  = r_data_last;
    assign full       = w_full;
    assign empty      = w_empty;

endmodule

`default_nettype wire
